// File: rtl/mic1_mem_pkg.sv
// -----------------------------------------------------------------------------
// mic1_mem_pkg
// Shared types and constants for the mic1 main-memory arbiter.
//   arb_state_t : arbiter FSM states (ARB, LOCK_LD, LOCK_CPU)
//   req_id_t    : requester identity (REQ_LD = serial loader, REQ_CPU = mic1)
//   IO_ADDR_DEFAULT : word address of the memory-mapped IO register
// -----------------------------------------------------------------------------
package mic1_mem_pkg;

    typedef enum logic [1:0] {
        ARB      = 2'd0,
        LOCK_LD  = 2'd1,
        LOCK_CPU = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_LD  = 1'b0,
        REQ_CPU = 1'b1
    } req_id_t;

    localparam logic [31:0] IO_ADDR_DEFAULT = 32'hFFFFFFFD;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant logic with its priority pointer.
// Ports:
//   clk, resetn            : clock, asynchronous active-low reset
//   ld_req_i, cpu_req_i    : eligible requests (lock masking done by caller)
//   ld_gnt_o, cpu_gnt_o    : one-hot-or-zero combinational grants
// The pointer names the requester that wins the next contested cycle and
// moves to the other requester after every grant, contested or not.
// -----------------------------------------------------------------------------
module rr_arb2
    import mic1_mem_pkg::*;
#(
    parameter logic RR_INIT = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic ld_req_i,
    input  logic cpu_req_i,
    output logic ld_gnt_o,
    output logic cpu_gnt_o
);

    req_id_t rr_q;
    req_id_t rr_d;

    always_comb begin
        ld_gnt_o  = 1'b0;
        cpu_gnt_o = 1'b0;
        if (ld_req_i && cpu_req_i) begin
            if (rr_q == REQ_LD) ld_gnt_o  = 1'b1;
            else                cpu_gnt_o = 1'b1;
        end else begin
            ld_gnt_o  = ld_req_i;
            cpu_gnt_o = cpu_req_i;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (ld_gnt_o)       rr_d = REQ_CPU;
        else if (cpu_gnt_o) rr_d = REQ_LD;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rr_q <= req_id_t'(RR_INIT);
        else         rr_q <= rr_d;
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates the serial loader and the mic1 data port onto main memory
// port A (1-cycle read latency) and a single memory-mapped IO register.
// Ports:
//   clk, resetn                         : clock, asynchronous active-low reset
//   ld_*  req/we/lock/addr/wdata -> gnt/rvalid/rdata : loader side
//   cpu_* req/we/lock/addr/wdata -> gnt/rvalid/rdata : mic1 side
//   mem_ren/wen/addr/wdata, mem_rdata   : main memory port
//   io_ren/wen/wdata, io_rdata          : IO register (combinational read)
// Grants are combinational; read data returns one cycle after the grant,
// steered by a registered response tag (owner, is_io).
// -----------------------------------------------------------------------------
module mem_arbiter
    import mic1_mem_pkg::*;
#(
    parameter logic [31:0] IO_ADDR = IO_ADDR_DEFAULT,
    parameter logic        RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ld_req,
    input  logic        ld_we,
    input  logic        ld_lock,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_wdata,
    output logic        ld_gnt,
    output logic        ld_rvalid,
    output logic [31:0] ld_rdata,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_lock,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        io_ren,
    output logic        io_wen,
    output logic [31:0] io_wdata,
    input  logic [31:0] io_rdata
);

    arb_state_t  state_q;
    logic        ld_elig, cpu_elig, any_gnt;
    logic        win_we, win_io, rd_gnt;
    logic [31:0] win_addr, win_wdata;
    logic [31:0] addr_q, wdata_q;
    logic        rvld_q, is_io_q;
    req_id_t     owner_q;
    logic [31:0] io_q, rsp_data;
    logic [31:0] ld_rdata_q, cpu_rdata_q;

    // A lock held by one side hides the other side from the arbiter; reset
    // hides both so no grant or strobe escapes while resetn is low.
    assign ld_elig  = ld_req  & resetn & (state_q != LOCK_CPU);
    assign cpu_elig = cpu_req & resetn & (state_q != LOCK_LD);

    rr_arb2 #(.RR_INIT(RR_INIT)) u_rr (
        .clk       (clk),
        .resetn    (resetn),
        .ld_req_i  (ld_elig),
        .cpu_req_i (cpu_elig),
        .ld_gnt_o  (ld_gnt),
        .cpu_gnt_o (cpu_gnt)
    );

    assign any_gnt   = ld_gnt | cpu_gnt;
    assign win_addr  = cpu_gnt ? cpu_addr  : ld_addr;
    assign win_wdata = cpu_gnt ? cpu_wdata : ld_wdata;
    assign win_we    = cpu_gnt ? cpu_we    : ld_we;
    assign win_io    = (win_addr == IO_ADDR);
    assign rd_gnt    = any_gnt & ~win_we;

    assign mem_ren = any_gnt & ~win_we & ~win_io;
    assign mem_wen = any_gnt &  win_we & ~win_io;
    assign io_ren  = any_gnt & ~win_we &  win_io;
    assign io_wen  = any_gnt &  win_we &  win_io;

    // Address/data bus follows the winner and otherwise holds the last grant.
    assign mem_addr  = any_gnt ? win_addr  : addr_q;
    assign mem_wdata = any_gnt ? win_wdata : wdata_q;
    assign io_wdata  = mem_wdata;

    // FSM: lock entry on a locked grant, exit on an unlocked grant or req drop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ARB;
        end else begin
            case (state_q)
                ARB: begin
                    if (ld_gnt && ld_lock)        state_q <= LOCK_LD;
                    else if (cpu_gnt && cpu_lock) state_q <= LOCK_CPU;
                end
                LOCK_LD: begin
                    if (!ld_req || (ld_gnt && !ld_lock))    state_q <= ARB;
                end
                LOCK_CPU: begin
                    if (!cpu_req || (cpu_gnt && !cpu_lock)) state_q <= ARB;
                end
                default: state_q <= ARB;
            endcase
        end
    end

    // Response tag and bus hold registers, captured at the grant edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rvld_q  <= 1'b0;
            owner_q <= REQ_LD;
            is_io_q <= 1'b0;
            io_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            rvld_q <= rd_gnt;
            if (any_gnt) begin
                owner_q <= cpu_gnt ? REQ_CPU : REQ_LD;
                is_io_q <= win_io;
                addr_q  <= win_addr;
                wdata_q <= win_wdata;
            end
            // IO reads are sampled at the grant edge, since io_rdata may move.
            if (rd_gnt && win_io) io_q <= io_rdata;
        end
    end

    assign rsp_data   = is_io_q ? io_q : mem_rdata;
    assign ld_rvalid  = rvld_q & (owner_q == REQ_LD);
    assign cpu_rvalid = rvld_q & (owner_q == REQ_CPU);

    // mem_rdata is only valid in the response cycle, so rdata is passed
    // through then and replayed from a holding register afterwards.
    assign ld_rdata  = ld_rvalid  ? rsp_data : ld_rdata_q;
    assign cpu_rdata = cpu_rvalid ? rsp_data : cpu_rdata_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ld_rdata_q  <= '0;
            cpu_rdata_q <= '0;
        end else begin
            ld_rdata_q  <= ld_rdata;
            cpu_rdata_q <= cpu_rdata;
        end
    end

endmodule
